// File: rtl/rx_pkt_queue.sv
// RX MAC byte stream to AXI-Stream store-and-forward frame queue.
// Frames become visible to the reader only after a good (or flagged bad) status.
module rx_pkt_queue #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int DEPTH_BITS      = 9,
    parameter bit DROP_BAD_FRAMES = 1,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_data_valid,
    input  logic                        rx_good_frame,
    input  logic                        rx_bad_frame,
    output logic [AXI_DATA_WIDTH-1:0]   tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] tstrb,
    output logic                        tvalid,
    output logic                        tlast,
    input  logic                        tready,
    output logic                        err_tvalid,
    output logic [CNT_WIDTH-1:0]        rx_drop_count
);

    localparam int N  = AXI_DATA_WIDTH / 8;
    localparam int CW = $clog2(N) + 1;
    localparam int PW = DEPTH_BITS + 1;
    localparam int WW = AXI_DATA_WIDTH + N + 2;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_BITS{1'b0}}};

    typedef enum logic [1:0] {
        W_IDLE,
        W_FRAME,
        W_STATUS,
        W_DROP
    } wstate_t;

    wstate_t                   state;
    wstate_t                   state_nx;
    logic [AXI_DATA_WIDTH-1:0] acc_data;
    logic [AXI_DATA_WIDTH-1:0] acc_data_nx;
    logic [AXI_DATA_WIDTH-1:0] acc_ins;
    logic [CW-1:0]             acc_cnt;
    logic [CW-1:0]             acc_cnt_nx;
    logic [N-1:0]              last_strb;
    logic [PW-1:0]             wr_spec;
    logic [PW-1:0]             wr_spec_nx;
    logic [PW-1:0]             wr_commit;
    logic [PW-1:0]             wr_commit_nx;
    logic [PW-1:0]             rd_ptr;
    logic                      wr_en;
    logic [WW-1:0]             wr_word;
    logic                      drop_inc;
    logic                      full;
    logic                      acc_full;
    logic                      closing;
    logic                      status;
    logic                      empty;
    logic                      load;
    logic [WW-1:0]             out_word;
    logic                      out_err;

    logic [WW-1:0] mem [0:(1<<DEPTH_BITS)-1];

    assign full     = (wr_spec - rd_ptr) == DEPTH;
    assign acc_full = acc_cnt == CW'(N);
    assign status   = rx_good_frame | rx_bad_frame;
    assign closing  = (state == W_STATUS) ||
                      (state == W_FRAME && !rx_data_valid);

    always_comb begin
        acc_ins   = acc_data;
        last_strb = '0;
        for (int i = 0; i < N; i++) begin
            if (acc_cnt == CW'(i)) acc_ins[8*i +: 8] = rx_data;
            last_strb[i] = CW'(i) < acc_cnt;
        end
    end

    always_comb begin
        state_nx     = state;
        acc_data_nx  = acc_data;
        acc_cnt_nx   = acc_cnt;
        wr_spec_nx   = wr_spec;
        wr_commit_nx = wr_commit;
        wr_en        = 1'b0;
        wr_word      = '0;
        drop_inc     = 1'b0;
        unique case (state)
            W_IDLE: begin
                if (rx_data_valid) begin
                    acc_data_nx = AXI_DATA_WIDTH'(rx_data);
                    acc_cnt_nx  = CW'(1);
                    state_nx    = W_FRAME;
                end
            end
            W_FRAME: begin
                if (!rx_data_valid) begin
                    state_nx = W_STATUS;
                end else if (!acc_full) begin
                    acc_data_nx = acc_ins;
                    acc_cnt_nx  = acc_cnt + CW'(1);
                end else if (full) begin
                    wr_spec_nx = wr_commit;
                    drop_inc   = 1'b1;
                    state_nx   = W_DROP;
                end else begin
                    wr_en       = 1'b1;
                    wr_word     = {1'b0, 1'b0, {N{1'b1}}, acc_data};
                    wr_spec_nx  = wr_spec + PW'(1);
                    acc_data_nx = AXI_DATA_WIDTH'(rx_data);
                    acc_cnt_nx  = CW'(1);
                end
            end
            W_STATUS: begin
                state_nx = W_STATUS;
            end
            W_DROP: begin
                if (!rx_data_valid) state_nx = W_IDLE;
            end
        endcase

        // End of frame: a status pulse settles it, a new byte abandons it
        if (closing) begin
            if (status) begin
                if ((rx_bad_frame && DROP_BAD_FRAMES) || full) begin
                    wr_spec_nx = wr_commit;
                    drop_inc   = 1'b1;
                end else begin
                    wr_en        = 1'b1;
                    wr_word      = {rx_bad_frame, 1'b1, last_strb, acc_data};
                    wr_spec_nx   = wr_spec + PW'(1);
                    wr_commit_nx = wr_spec + PW'(1);
                end
                state_nx = W_IDLE;
            end else if (rx_data_valid) begin
                wr_spec_nx = wr_commit;
                drop_inc   = 1'b1;
            end
            if (rx_data_valid) begin
                acc_data_nx = AXI_DATA_WIDTH'(rx_data);
                acc_cnt_nx  = CW'(1);
                state_nx    = W_FRAME;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= W_IDLE;
            acc_data      <= '0;
            acc_cnt       <= '0;
            wr_spec       <= '0;
            wr_commit     <= '0;
            rx_drop_count <= '0;
        end else begin
            state     <= state_nx;
            acc_data  <= acc_data_nx;
            acc_cnt   <= acc_cnt_nx;
            wr_spec   <= wr_spec_nx;
            wr_commit <= wr_commit_nx;
            if (drop_inc && rx_drop_count != '1)
                rx_drop_count <= rx_drop_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_spec[DEPTH_BITS-1:0]] <= wr_word;
    end

    // Read address never passes wr_commit, so it never meets a live write
    assign empty = rd_ptr == wr_commit;
    assign load  = !empty && (!tvalid || tready);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            tvalid   <= 1'b0;
            out_word <= '0;
        end else if (load) begin
            out_word <= mem[rd_ptr[DEPTH_BITS-1:0]];
            rd_ptr   <= rd_ptr + PW'(1);
            tvalid   <= 1'b1;
        end else if (tready) begin
            tvalid   <= 1'b0;
        end
    end

    assign {out_err, tlast, tstrb, tdata} = out_word;
    assign err_tvalid = tvalid & out_err;

endmodule

// File: tb/tb_rx_pkt_queue.sv
// Bench for rx_pkt_queue: three instances (deep/drop, deep/forward, shallow/drop)
// share one MAC stream and are checked against a frame-level model.
module tb_rx_pkt_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_good_frame;
    logic        rx_bad_frame;
    logic [31:0] tdata [3];
    logic [3:0]  tstrb [3];
    logic        tvalid [3];
    logic        tlast [3];
    logic        tready [3];
    logic        err_tvalid [3];
    logic [31:0] drop_count [3];

    int vectors = 0;
    int miscompares = 0;
    int rmode;

    logic [37:0] mq [3][0:1023];
    int          hd [3];
    int          tl [3];
    int          mdrop [3];
    logic [37:0] held [3];
    logic        stl [3];
    logic [7:0]  fb [0:63];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rx_pkt_queue #(
            .AXI_DATA_WIDTH (32),
            .DEPTH_BITS     (g == 2 ? 4 : 9),
            .DROP_BAD_FRAMES(g != 1),
            .CNT_WIDTH      (32)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .rx_data      (rx_data),
            .rx_data_valid(rx_data_valid),
            .rx_good_frame(rx_good_frame),
            .rx_bad_frame (rx_bad_frame),
            .tdata        (tdata[g]),
            .tstrb        (tstrb[g]),
            .tvalid       (tvalid[g]),
            .tlast        (tlast[g]),
            .tready       (tready[g]),
            .err_tvalid   (err_tvalid[g]),
            .rx_drop_count(drop_count[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int pend(input int g);
        return tl[g] - hd[g];
    endfunction

    task automatic monitor();
        for (int g = 0; g < 3; g++) begin
            logic [37:0] cur;
            cur = {err_tvalid[g], tlast[g], tstrb[g], tdata[g]};
            if (stl[g])
                chk($sformatf("hold%0d", g), 64'({tvalid[g], cur}),
                    64'({1'b1, held[g]}));
            if (tvalid[g] && tready[g]) begin
                if (pend(g) == 0) begin
                    chk($sformatf("extra_beat%0d", g), 64'(cur), 64'h3_0000_0000_0);
                end else begin
                    chk($sformatf("beat%0d_%0d", g, hd[g]), 64'(cur),
                        64'(mq[g][hd[g] % 1024]));
                    hd[g]++;
                end
            end
            stl[g]  = tvalid[g] && !tready[g];
            held[g] = cur;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!reset) monitor();
        else for (int g = 0; g < 3; g++) stl[g] = 1'b0;
        @(posedge clk);
        #1;
        if (rmode == 1) begin
            for (int g = 0; g < 3; g++) tready[g] = ~tready[g];
        end else if (rmode == 2) begin
            tready[0] = 1'($urandom_range(0, 1));
            tready[1] = 1'($urandom_range(0, 1));
            tready[2] = 1'b1;
        end
    endtask

    // Frame outcome: dropped bad frame, overflow, or a list of 32-bit beats
    task automatic model_commit(input int len, input bit bad);
        int words;
        int occ;
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        words = (len + 3) / 4;
        for (int g = 0; g < 3; g++) begin
            occ = pend(g) - (pend(g) > 0 ? 1 : 0);
            if (bad && g != 1) begin
                mdrop[g]++;
            end else if (occ + words > (g == 2 ? 16 : 512)) begin
                mdrop[g]++;
            end else begin
                for (int w = 0; w < words; w++) begin
                    d = '0;
                    s = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (4*w + b < len) begin
                            d[8*b +: 8] = fb[4*w + b];
                            s[b] = 1'b1;
                        end
                    end
                    l = (w == words - 1);
                    mq[g][tl[g] % 1024] = {l & bad, l, s, d};
                    tl[g]++;
                end
            end
        end
    endtask

    // kind: 0 good, 1 bad, 2 good+bad, 3 abandoned (no status)
    task automatic send_frame(input int len, input int kind,
                              input int dly, input int gap);
        for (int i = 0; i < len; i++) begin
            rx_data = fb[i];
            rx_data_valid = 1'b1;
            step();
        end
        rx_data_valid = 1'b0;
        rx_data = '0;
        repeat (dly) step();
        if (kind == 3) begin
            for (int g = 0; g < 3; g++) mdrop[g]++;
            return;
        end
        rx_good_frame = (kind == 0 || kind == 2);
        rx_bad_frame  = (kind != 0);
        step();
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        model_commit(len, kind != 0);
        repeat (gap) step();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((pend(0) != 0 || pend(1) != 0 || pend(2) != 0) && n < 3000) begin
            step();
            n++;
        end
        for (int g = 0; g < 3; g++)
            chk($sformatf("%s_left%0d", tag, g), 64'(pend(g)), 64'd0);
        repeat (4) step();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_idle%0d", tag, g), 64'(tvalid[g]), 64'd0);
            chk($sformatf("%s_drops%0d", tag, g), 64'(drop_count[g]),
                64'(mdrop[g]));
        end
    endtask

    initial begin
        int len;
        int kind;
        reset = 1'b1;
        rx_data = '0;
        rx_data_valid = 1'b0;
        rx_good_frame = 1'b0;
        rx_bad_frame = 1'b0;
        rmode = 0;
        for (int g = 0; g < 3; g++) begin
            tready[g] = 1'b1;
            hd[g] = 0;
            tl[g] = 0;
            mdrop[g] = 0;
            stl[g] = 1'b0;
            held[g] = '0;
        end
        repeat (3) step();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_out%0d", g), 64'({err_tvalid[g], tlast[g],
                tvalid[g], tstrb[g], tdata[g]}), 64'd0);
            chk($sformatf("rst_cnt%0d", g), 64'(drop_count[g]), 64'd0);
        end
        reset = 1'b0;
        step();

        for (int i = 0; i < 64; i++) fb[i] = 8'(i);
        send_frame(64, 0, 1, 2);
        drain("t1");
        send_frame(61, 0, 1, 2);
        drain("t2");

        for (int i = 0; i < 20; i++) fb[i] = 8'(8'hA0 + i);
        send_frame(20, 1, 1, 2);
        drain("t3");

        for (int g = 0; g < 3; g++) tready[g] = 1'b0;
        for (int i = 0; i < 40; i++) fb[i] = 8'(8'h40 + i);
        send_frame(40, 0, 1, 3);
        for (int i = 0; i < 40; i++) fb[i] = 8'($urandom);
        send_frame(40, 0, 1, 3);
        repeat (5) step();
        for (int g = 0; g < 3; g++) tready[g] = 1'b1;
        drain("t4");

        rmode = 1;
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
        send_frame(64, 0, 1, 0);
        drain("t5");
        rmode = 0;
        for (int g = 0; g < 3; g++) tready[g] = 1'b1;

        for (int i = 0; i < 20; i++) begin
            rx_data = 8'(i);
            rx_data_valid = 1'b1;
            step();
        end
        rx_data_valid = 1'b0;
        reset = 1'b1;
        step();
        for (int g = 0; g < 3; g++) begin
            hd[g] = tl[g];
            mdrop[g] = 0;
            chk($sformatf("t6_rst%0d", g), 64'({err_tvalid[g], tlast[g],
                tvalid[g], tstrb[g], tdata[g], drop_count[g]}), 64'd0);
        end
        reset = 1'b0;
        step();
        rx_good_frame = 1'b1;
        step();
        rx_good_frame = 1'b0;
        step();
        fb[0] = 8'h11;
        fb[1] = 8'h22;
        fb[2] = 8'h33;
        fb[3] = 8'h44;
        send_frame(4, 0, 1, 2);
        drain("t6");

        rmode = 2;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 64);
            for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
            kind = $urandom_range(0, 9);
            kind = kind < 6 ? 0 : kind < 8 ? 1 : kind == 8 ? 2 : 3;
            send_frame(len, kind,
                       kind == 3 ? $urandom_range(1, 3) : $urandom_range(0, 3),
                       $urandom_range(0, 3));
        end
        for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
        send_frame(8, 0, 1, 2);
        drain("rnd");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
